color_set_detector: RTL

//  Parametrised successor to the 3-colour ball-box detector. It watches a stream of

---
 rtl/color_set_detector_if.sv | 27 ++
 rtl/color_set_detector.sv | 124 ++++++++++++
 2 files changed

// File: rtl/color_set_detector_if.sv
// Ball-stream bundle between sensor decoder (master) and colour-set detector (slave).
// Inputs are sampled each rising edge; there is no backpressure, every valid ball is consumed.
interface color_set_detector_if #(
  parameter int NUM_COLORS = 3,
  parameter int COLOR_W    = 2,
  parameter int CNT_W      = 8
);
  logic                  clear;
  logic                  in_valid;
  logic [COLOR_W-1:0]    in;
  logic                  dup_mode;
  logic                  det;
  logic                  err;
  logic                  timeout;
  logic [NUM_COLORS-1:0] seen;
  logic [CNT_W-1:0]      set_count;

  modport master (
    output clear, in_valid, in, dup_mode,
    input  det, err, timeout, seen, set_count
  );

  modport slave (
    input  clear, in_valid, in, dup_mode,
    output det, err, timeout, seen, set_count
  );
endinterface

// File: rtl/color_set_detector.sv
// Flags each time one ball of every colour has been collected; one-cycle latency, all outputs registered.
// No backpressure: every valid ball is acted on in the cycle it arrives.
module color_set_detector #(
  parameter int NUM_COLORS = 3,
  parameter int COLOR_W    = 2,
  parameter int MAX_BALLS  = 6,
  parameter int CNT_W      = 8
) (
  input logic                 clk,
  input logic                 rst,
  color_set_detector_if.slave bus
);
  localparam int BC_W = $clog2(MAX_BALLS + 1);
  localparam logic [COLOR_W:0]      NC_LIM   = (COLOR_W + 1)'(NUM_COLORS);
  localparam logic [BC_W-1:0]       BC_MAX   = BC_W'(MAX_BALLS);
  localparam logic [BC_W-1:0]       BC_ONE   = BC_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [NUM_COLORS-1:0] ALL_SEEN = {NUM_COLORS{1'b1}};

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e                state_q, state_d;
  logic [NUM_COLORS-1:0] seen_q, seen_d;
  logic [BC_W-1:0]       ball_cnt_q, ball_cnt_d;
  logic [CNT_W-1:0]      set_count_q, set_count_d;
  logic                  det_q, det_d;
  logic                  err_q, err_d;
  logic                  timeout_q, timeout_d;

  logic                  color_ok;
  logic [NUM_COLORS-1:0] onehot;
  logic [NUM_COLORS-1:0] seen_base;
  logic [NUM_COLORS-1:0] seen_nxt;
  logic [BC_W-1:0]       cnt_nxt;

  assign color_ok  = ({1'b0, bus.in} < NC_LIM);
  assign onehot    = NUM_COLORS'(1) << bus.in;
  // In IDLE the mask is empty by construction; use that rather than trusting seen_q.
  assign seen_base = (state_q == IDLE) ? '0 : seen_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      seen_q      <= '0;
      ball_cnt_q  <= '0;
      set_count_q <= '0;
      det_q       <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_q      <= seen_d;
      ball_cnt_q  <= ball_cnt_d;
      set_count_q <= set_count_d;
      det_q       <= det_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    seen_d      = seen_q;
    ball_cnt_d  = ball_cnt_q;
    set_count_d = set_count_q;
    det_d       = 1'b0;
    err_d       = 1'b0;
    timeout_d   = 1'b0;
    seen_nxt    = seen_base;
    cnt_nxt     = ball_cnt_q;

    if (bus.clear) begin
      state_d     = IDLE;
      seen_d      = '0;
      ball_cnt_d  = '0;
      set_count_d = '0;
    end else if (bus.in_valid) begin
      if (!color_ok) begin
        err_d      = 1'b1;
        state_d    = IDLE;
        seen_d     = '0;
        ball_cnt_d = '0;
      end else if ((seen_base | onehot) == ALL_SEEN) begin
        // Completion is checked before the ball count, so it wins over timeout.
        det_d       = 1'b1;
        set_count_d = (set_count_q == CNT_SAT) ? set_count_q : set_count_q + CNT_ONE;
        state_d     = IDLE;
        seen_d      = '0;
        ball_cnt_d  = '0;
      end else begin
        if ((seen_base & onehot) == '0) begin
          seen_nxt = seen_base | onehot;
          cnt_nxt  = ball_cnt_q + BC_ONE;
        end else if (!bus.dup_mode) begin
          seen_nxt = seen_base;
          cnt_nxt  = ball_cnt_q + BC_ONE;
        end else begin
          seen_nxt = onehot;
          cnt_nxt  = BC_ONE;
        end

        if (cnt_nxt == BC_MAX) begin
          timeout_d  = 1'b1;
          state_d    = IDLE;
          seen_d     = '0;
          ball_cnt_d = '0;
        end else begin
          state_d    = COLLECT;
          seen_d     = seen_nxt;
          ball_cnt_d = cnt_nxt;
        end
      end
    end
  end

  always_comb begin
    bus.det       = det_q;
    bus.err       = err_q;
    bus.timeout   = timeout_q;
    bus.seen      = seen_q;
    bus.set_count = set_count_q;
  end
endmodule
